bus_arbiter4: RTL and testbench

//  Four-requester bus arbiter sharing one datapath resource (e.g. the memory/ALU bus).

---
 rtl/bus_arbiter4_pkg.sv | 14 +
 rtl/bus_arbiter4_arb_pick.sv | 27 ++
 rtl/bus_arbiter4.sv | 115 +++++++++++
 tb/tb_bus_arbiter4.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter4_pkg.sv
// Shared types and constants for the four-requester bus arbiter.
// State encodings are fixed so that debug probes can decode them.
package bus_arbiter4_pkg;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      GAP  = 2'b10
   } state_t;

endpackage

// File: rtl/bus_arbiter4_arb_pick.sv
// Rotated priority select: scans req from base+1 upward, wrapping mod 4,
// and returns the first set index.
module arb_pick
   import bus_arbiter4_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  base,
   output logic [ID_W-1:0]  id,
   output logic             hit
);

   logic [ID_W-1:0] idx;

   always_comb begin
      id  = '0;
      hit = 1'b0;
      idx = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = base + ID_W'(k);
         if (!hit && req[idx]) begin
            id  = idx;
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter4.sv
// Four-requester bus arbiter with hold watchdog and one-cycle turnaround gap.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority (3 highest).
module bus_arbiter4
   import bus_arbiter4_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             grant_valid,
   output logic             timeout
);

   state_t          state;
   state_t          state_nx;
   logic [ID_W-1:0] owner;
   logic [CNT_W-1:0] cnt;
   logic            to_q;

   logic [N_REQ-1:0] pick_req;
   logic [ID_W-1:0]  pick_base;
   logic [ID_W-1:0]  pick_id;
   logic [ID_W-1:0]  win_id;
   logic             pick_hit;

   logic rel_done;
   logic rel_to;
   logic release_now;

`ifdef BUS_ARB_ROUND_ROBIN_EN
   logic [ID_W-1:0] last_id;

   assign pick_req  = req;
   assign pick_base = last_id;
   assign win_id    = pick_id;
`else
   // Reversing req turns the lowest-first scan into highest-index-wins.
   assign pick_req  = {req[0], req[1], req[2], req[3]};
   assign pick_base = 2'b11;
   assign win_id    = ~pick_id;
`endif

   arb_pick u_pick (
      .req  (pick_req),
      .base (pick_base),
      .id   (pick_id),
      .hit  (pick_hit)
   );

   assign rel_done    = done | ~req[owner];
   assign rel_to      = (cnt == CNT_W'(MAX_HOLD - 1));
   assign release_now = rel_done | rel_to;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         owner <= '0;
         cnt   <= '0;
         to_q  <= 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
         last_id <= 2'b11;
`endif
      end else begin
         state <= state_nx;
         to_q  <= (state == BUSY) && release_now && !rel_done;
         unique case (state)
            IDLE: begin
               if (enable && pick_hit) begin
                  owner <= win_id;
                  cnt   <= '0;
               end
            end
            BUSY: begin
               if (release_now) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
                  last_id <= owner;
`endif
               end else if (!rel_to) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (enable && pick_hit) state_nx = BUSY;
         BUSY:    if (release_now) state_nx = GAP;
         GAP:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      grant       = '0;
      grant_id    = '0;
      grant_valid = 1'b0;
      if (state == BUSY) begin
         grant_valid  = 1'b1;
         grant_id     = owner;
         grant[owner] = 1'b1;
      end
      timeout = (state == GAP) && to_q;
   end

endmodule

// File: tb/tb_bus_arbiter4.sv
// Table-driven scoreboard bench for bus_arbiter4 (MAX_HOLD=4).
// Expectations depend on whether BUS_ARB_ROUND_ROBIN_EN is defined.
module tb_bus_arbiter4;

   typedef struct {
      logic       en;
      logic [3:0] req;
      logic       done;
      logic [7:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] req = 4'b1111;
   logic       done = 1'b0;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       grant_valid;
   logic       timeout;

   int checks = 0;
   int failures = 0;
   vec_t vt[$];
   logic [7:0] sb[$];

   bus_arbiter4 #(.MAX_HOLD(4), .CNT_W(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic e, logic [3:0] r, logic d,
                               logic [3:0] g, logic [1:0] id,
                               logic v, logic t);
      vec_t x;
      x.en = e;
      x.req = r;
      x.done = d;
      x.exp = {g, id, v, t};
      return x;
   endfunction

   function automatic logic [7:0] outs();
      return {grant, grant_id, grant_valid, timeout};
   endfunction

   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got={g=%b id=%0d v=%b to=%b} want={g=%b id=%0d v=%b to=%b}",
                  name, act[7:4], act[3:2], act[1], act[0],
                  exp[7:4], exp[3:2], exp[1], exp[0]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      vt.push_back(mk(1, 4'b1111, 0, 4'b0001, 0, 1, 0));
      vt.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b1111, 0, 4'b0010, 1, 1, 0));
      vt.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b1111, 0, 4'b0100, 2, 1, 0));
      vt.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b1111, 0, 4'b1000, 3, 1, 0));
      vt.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b1111, 0, 4'b0001, 0, 1, 0));
      vt.push_back(mk(1, 4'b1111, 0, 4'b0001, 0, 1, 0));
`else
      // reset release then fixed priority
      vt.push_back(mk(1, 4'b1111, 0, 4'b1000, 3, 1, 0));
      vt.push_back(mk(1, 4'b0110, 0, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b0110, 0, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b0110, 0, 4'b0100, 2, 1, 0));
      vt.push_back(mk(1, 4'b0110, 1, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b0110, 0, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b0110, 0, 4'b0100, 2, 1, 0));
      vt.push_back(mk(1, 4'b0110, 1, 4'b0000, 0, 0, 0));
      // watchdog release
      vt.push_back(mk(1, 4'b0001, 0, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b0001, 0, 4'b0001, 0, 1, 0));
      vt.push_back(mk(1, 4'b0001, 0, 4'b0001, 0, 1, 0));
      vt.push_back(mk(1, 4'b0001, 0, 4'b0001, 0, 1, 0));
      vt.push_back(mk(1, 4'b0001, 0, 4'b0001, 0, 1, 0));
      vt.push_back(mk(1, 4'b0001, 0, 4'b0000, 0, 0, 1));
      vt.push_back(mk(1, 4'b0001, 0, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b0001, 0, 4'b0001, 0, 1, 0));
      // done coincides with last hold cycle
      vt.push_back(mk(1, 4'b0001, 0, 4'b0001, 0, 1, 0));
      vt.push_back(mk(1, 4'b0001, 0, 4'b0001, 0, 1, 0));
      vt.push_back(mk(1, 4'b0001, 0, 4'b0001, 0, 1, 0));
      vt.push_back(mk(1, 4'b0001, 1, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b0001, 0, 4'b0000, 0, 0, 0));
      // enable gating
      vt.push_back(mk(0, 4'b0010, 0, 4'b0000, 0, 0, 0));
      vt.push_back(mk(0, 4'b0010, 0, 4'b0000, 0, 0, 0));
      vt.push_back(mk(1, 4'b0010, 0, 4'b0010, 1, 1, 0));
      vt.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 1, 0));
      vt.push_back(mk(0, 4'b0010, 1, 4'b0000, 0, 0, 0));
      vt.push_back(mk(0, 4'b0010, 0, 4'b0000, 0, 0, 0));
      vt.push_back(mk(0, 4'b0010, 0, 4'b0000, 0, 0, 0));
      // owner for the mid-grant reset
      vt.push_back(mk(1, 4'b1111, 0, 4'b1000, 3, 1, 0));
`endif

      // outputs held at zero while in reset, even with all requests up
      #3;
      check("reset_outputs", outs(), 8'h00);

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk);
         rst_n  = 1'b1;
         enable = vt[i].en;
         req    = vt[i].req;
         done   = vt[i].done;
         sb.push_back(vt[i].exp);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            check($sformatf("scoreboard_empty_%0d", i), outs(), 8'hxx);
         end else begin
            check($sformatf("vec_%0d", i), outs(), sb.pop_front());
         end
      end

      // asynchronous reset in the middle of a tenure
      #2;
      check("pre_reset_owner", {3'b000, grant_valid, 4'h0}, 8'h10);
      rst_n = 1'b0;
      #1;
      check("async_reset_drop", outs(), 8'h00);
      @(negedge clk);
      check("reset_held", outs(), 8'h00);
      done = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      check("post_reset_rr_start", outs(), {4'b0001, 2'd0, 1'b1, 1'b0});
`else
      check("post_reset_regrant", outs(), {4'b1000, 2'd3, 1'b1, 1'b0});
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
